// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - round-robin serializer of button press/release/repeat events
module btn_event_arbiter #(
  parameter int                N_BTN      = 4,
  parameter int                ID_W       = 2,
  parameter int                CNT_W      = 24,
  parameter logic [CNT_W-1:0]  HOLD_CYC   = 24'd5000000,
  parameter logic [CNT_W-1:0]  REPEAT_CYC = 24'd1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type,
  output logic [ID_W-1:0]  evt_id,
  output logic [7:0]       drop_cnt
);

  localparam logic [CNT_W-1:0] L_HOLD_M1 = HOLD_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] L_RPT_M1  = REPEAT_CYC - CNT_W'(1);
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  logic [N_BTN-1:0] r_btn_q, r_rep, r_rpt, r_ph;
  logic [CNT_W-1:0] r_hc [N_BTN];
  logic [ID_W-1:0]  r_ptr;

  logic [N_BTN-1:0]   w_chg, w_req, w_rot, w_gnt_oh, w_hit, w_drop;
  logic [2*N_BTN-1:0] w_req2;
  logic               w_free, w_found, w_grant, w_sel_chg, w_sel_lvl;
  logic [ID_W-1:0]    w_gnt_id, w_nxt_ptr;
  logic [ID_W:0]      w_sum;
  logic [4:0]         w_ndrop;
  logic [8:0]         w_drop_sum;

  assign w_chg   = r_btn_q ^ r_rep;
  assign w_req   = w_chg | r_rpt;
  assign w_free  = !evt_valid || evt_ready;
  // Rotate requests so bit 0 is the button at ptr; first set bit wins.
  assign w_req2  = {w_req, w_req} >> r_ptr;
  assign w_rot   = w_req2[N_BTN-1:0];
  assign w_grant = w_free && w_found;

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_sum    = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (ID_W+1)'(k);
        if (w_sum >= (ID_W+1)'(N_BTN)) w_sum = w_sum - (ID_W+1)'(N_BTN);
        w_gnt_id = w_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < N_BTN; i++) w_gnt_oh[i] = w_grant && (w_gnt_id == ID_W'(i));
  end

  assign w_sel_chg = |(w_gnt_oh & w_chg);
  assign w_sel_lvl = |(w_gnt_oh & r_btn_q);
  assign w_nxt_ptr = (w_gnt_id == ID_W'(N_BTN - 1)) ? '0 : w_gnt_id + ID_W'(1);

  // A repeat that matures while the previous one is still unserved is lost.
  always_comb begin
    w_hit   = '0;
    w_drop  = '0;
    w_ndrop = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_hit[i]  = r_btn_q[i] && r_rep[i] && (r_hc[i] == (r_ph[i] ? L_RPT_M1 : L_HOLD_M1));
      w_drop[i] = w_hit[i] && r_rpt[i] && !(w_gnt_oh[i] && !w_chg[i]);
      w_ndrop   = w_ndrop + {4'b0, w_drop[i]};
    end
  end

  assign w_drop_sum = {1'b0, drop_cnt} + {4'b0, w_ndrop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_q   <= '0;
      r_rep     <= '0;
      r_rpt     <= '0;
      r_ph      <= '0;
      r_ptr     <= '0;
      for (int i = 0; i < N_BTN; i++) r_hc[i] <= '0;
      evt_valid <= 1'b0;
      evt_type  <= 2'b00;
      evt_id    <= '0;
      drop_cnt  <= '0;
    end else begin
      r_btn_q <= btn_in;
      if (w_free) begin
        evt_valid <= w_found;
        if (w_found) begin
          evt_type <= w_sel_chg ? (w_sel_lvl ? EVT_PRESS : EVT_RELEASE) : EVT_REPEAT;
          evt_id   <= w_gnt_id;
          r_ptr    <= w_nxt_ptr;
        end
      end
      drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      for (int i = 0; i < N_BTN; i++) begin
        if (w_gnt_oh[i] && w_chg[i]) r_rep[i] <= r_btn_q[i];
        if (!r_btn_q[i] || !r_rep[i]) begin
          r_hc[i] <= '0;
          r_ph[i] <= 1'b0;
        end else if (w_hit[i]) begin
          r_hc[i] <= '0;
          r_ph[i] <= 1'b1;
        end else begin
          r_hc[i] <= r_hc[i] + CNT_W'(1);
        end
        if (!r_btn_q[i])                    r_rpt[i] <= 1'b0;
        else if (w_hit[i])                  r_rpt[i] <= 1'b1;
        else if (w_gnt_oh[i] && !w_chg[i])  r_rpt[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - directed vector bench for btn_event_arbiter
module tb_btn_event_arbiter;
  localparam int N_BTN = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_in;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_type;
  logic [ID_W-1:0]  evt_id;
  logic [7:0]       drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] btn;
    logic       rdy;
    logic       ck;
    logic       v;
    logic [1:0] t;
    logic [1:0] id;
    logic [7:0] drop;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  btn_event_arbiter #(
    .N_BTN(N_BTN), .ID_W(ID_W), .CNT_W(CNT_W),
    .HOLD_CYC(24'd8), .REPEAT_CYC(24'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_type(evt_type), .evt_id(evt_id), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] b, input logic rd, input logic ck,
                     input logic v, input logic [1:0] t, input logic [1:0] id, input logic [7:0] d);
    vec_t x;
    x.rst_n = r; x.btn = b; x.rdy = rd; x.ck = ck; x.v = v; x.t = t; x.id = id; x.drop = d;
    vq.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; btn_in = '0; evt_ready = 1'b1;

    // single press/release on button 2
    add(1, 4'b0100, 1, 1, 0, 2'b00, 0, 0);
    add(1, 4'b0100, 1, 1, 1, 2'b01, 2, 0);
    for (int n = 0; n < 4; n++) add(1, 4'b0100, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0000, 1, 1, 1, 2'b10, 2, 0);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0);

    // round-robin press then release, ptr wraps back to 0
    add(0, 4'b0000, 1, 1, 0, 2'b00, 0, 0);
    add(1, 4'b1111, 1, 1, 0, 2'b00, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 4'b1111, 1, 1, 1, 2'b01, 2'(k), 0);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 4'b0000, 1, 1, 1, 2'b10, 2'(k), 0);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 0);

    // backpressure: button 1 stalls, repeats of button 1 drop while stalled
    add(0, 4'b0000, 0, 1, 0, 2'b00, 0, 0);
    for (int n = 1; n <= 20; n++)
      add(1, 4'b1010, 0, n >= 2, n >= 2, 2'b01, 1, (n >= 18) ? 8'd2 : (n >= 14) ? 8'd1 : 8'd0);
    add(1, 4'b1010, 1, 1, 1, 2'b01, 3, 2);
    add(1, 4'b1010, 1, 1, 1, 2'b11, 1, 2);
    add(1, 4'b1010, 1, 1, 1, 2'b11, 1, 2);
    add(1, 4'b1010, 1, 0, 0, 0, 0, 2);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 2);
    add(1, 4'b0000, 1, 1, 1, 2'b10, 3, 2);
    add(1, 4'b0000, 1, 1, 1, 2'b10, 1, 2);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 2);

    // auto-repeat on button 0: press, 5 repeats, release
    add(0, 4'b0000, 1, 1, 0, 2'b00, 0, 0);
    for (int n = 1; n <= 31; n++) begin
      logic rp;
      rp = (n == 11) || (n == 15) || (n == 19) || (n == 23) || (n == 27);
      if (n == 2)       add(1, 4'b0001, 1, 1, 1, 2'b01, 0, 0);
      else if (rp)      add(1, 4'b0001, 1, 1, 1, 2'b11, 0, 0);
      else if (n == 30) add(1, 4'b0000, 1, 1, 1, 2'b10, 0, 0);
      else              add(1, (n <= 28) ? 4'b0001 : 4'b0000, 1, 0, 0, 0, 0, 0);
    end

    // reset while an event is stalled and the button is held
    add(0, 4'b0000, 0, 1, 0, 2'b00, 0, 0);
    add(1, 4'b0010, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0010, 0, 1, 1, 2'b01, 1, 0);
    add(0, 4'b0010, 0, 1, 0, 2'b00, 0, 0);
    add(1, 4'b0010, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0010, 1, 1, 1, 2'b01, 1, 0);
    add(1, 4'b0010, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", int'(evt_valid), 0);
    chk("reset type", int'(evt_type), 0);
    chk("reset id", int'(evt_id), 0);
    chk("reset drop", int'(drop_cnt), 0);

    foreach (vq[n]) begin
      @(negedge clk);
      rst_n = vq[n].rst_n; btn_in = vq[n].btn; evt_ready = vq[n].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d valid", n), int'(evt_valid), int'(vq[n].v));
      if (vq[n].ck) begin
        chk($sformatf("row%0d type", n), int'(evt_type), int'(vq[n].t));
        chk($sformatf("row%0d id", n), int'(evt_id), int'(vq[n].id));
      end
      chk($sformatf("row%0d drop", n), int'(drop_cnt), int'(vq[n].drop));
    end

    // long stall: drop_cnt climbs every 4 cycles and saturates at 255
    @(negedge clk);
    rst_n = 1'b0; btn_in = '0; evt_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      rst_n = 1'b1; btn_in = 4'b0001; evt_ready = (c <= 3);
      @(posedge clk);
      #1;
      if (c == 11) begin
        chk("sat first repeat valid", int'(evt_valid), 1);
        chk("sat first repeat type", int'(evt_type), 3);
      end
      if (c == 17)   chk("sat drop c17", int'(drop_cnt), 0);
      if (c == 18)   chk("sat drop c18", int'(drop_cnt), 1);
      if (c == 30)   chk("sat drop c30", int'(drop_cnt), 4);
      if (c == 1033) chk("sat drop c1033", int'(drop_cnt), 254);
      if (c == 1034) chk("sat drop c1034", int'(drop_cnt), 255);
      if (c == 1100) begin
        chk("sat drop c1100", int'(drop_cnt), 255);
        chk("sat held valid", int'(evt_valid), 1);
        chk("sat held type", int'(evt_type), 3);
        chk("sat held id", int'(evt_id), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Converts the debounced levels of N buttons into a serialized stream of press, release and auto-repeat events, one per clock at most. It sits between the per-button `debounce` instances and the game logic. Requesters (buttons) share a single event output through a round-robin arbiter with valid/ready backpressure. No edge is lost: the final button state is always reported, even when the output is stalled.

## Interface
- `N_BTN`, 4: number of buttons; legal range 2..16.
- `ID_W`, 2: width of `evt_id`; must equal max(1, clog2(N_BTN)).
- `CNT_W`, 24: width of the hold/repeat counters.
- `HOLD_CYC`, 24'd5000000: cycles a button must stay held before the first repeat event; must be ≥ 2.
- `REPEAT_CYC`, 24'd1000000: cycles between subsequent repeat events; must be ≥ 2.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `btn_in` in N_BTN: debounced button levels; 1 = pressed.
- `evt_valid` out 1: event slot holds an event.
- `evt_ready` in 1: consumer accepts the event this cycle.
- `evt_type` out 2: event type; 2'b01 = press, 2'b10 = release, 2'b11 = repeat. The value 2'b00 appears only while `evt_valid` = 0 after reset.
- `evt_id` out ID_W: index of the button that produced the event.
- `drop_cnt` out 8: saturating count of repeat events lost.

## Operation
- **Input sampling.** `btn_q` <= `btn_in` every cycle.
- **Reported state.** `rep[i]` is the last state reported for button i.
  - A transition is pending when `btn_q[i]` != `rep[i]`.
  - The pending event is a press if `btn_q[i]` = 1, else a release.
  - `rep[i]` toggles only when button i is granted with a press or release event.
  - A press+release pair that occurs entirely while the button is not yet granted collapses to no event. This is accepted behaviour.
- **Hold counter `hc[i]` and phase `ph[i]`.**
  - Both clear when `btn_q[i]` = 0, when `rep[i]` = 0, or when a press for button i is granted.
  - Otherwise `hc[i]` increments each cycle.
  - The threshold is `HOLD_CYC` when `ph[i]` = 0 and `REPEAT_CYC` when `ph[i]` = 1.
  - When `hc[i]` = threshold−1: `hc[i]` <= 0, `ph[i]` <= 1, and `rpt[i]` <= 1.
  - If `rpt[i]` is already 1 at that moment, `drop_cnt` increments, saturating at 255.
- **Repeat pending `rpt[i]`.**
  - Clears when a repeat for button i is granted.
  - Also clears when `btn_q[i]` = 0; this clear is silent and is not counted in `drop_cnt`.
- **Request.** `req[i]` = (`btn_q[i]` != `rep[i]`) | `rpt[i]`.
  - Within a button, a press/release takes precedence over a repeat.
  - The repeat stays pending in that case.
- **Arbiter.**
  - The output slot is free when `evt_valid` = 0 or when `evt_ready` = 1.
  - When the slot is free and any `req` is set, grant the first i with `req[i]` set, searching from `ptr` upward with wrap-around.
  - Load the slot with (type, i), then set `ptr` <= (i+1) mod N_BTN.
- **Output hold.** While `evt_valid` = 1 and `evt_ready` = 0, `evt_type`, `evt_id` and `evt_valid` hold unchanged.

## Timing
- **Reset values.** `evt_valid`=0, `evt_type`=0, `evt_id`=0, `drop_cnt`=0.
- **Internal reset state.** `btn_q`=0, `rep`=0, `rpt`=0, `hc`=0, `ph`=0, `ptr`=0.
- **Button held through reset.** This yields a press event after `rst_n` rises.
- **Reset mid-operation.** Asserting reset discards any slot contents and all pending events on the next edge.
- **Latency.**
  - `btn_in` changes before edge k; `btn_q` updates at edge k; the grant happens at edge k+1.
  - `evt_valid`=1 after edge k+1, provided the slot was free.
- **Throughput.** One event per cycle. The slot reloads in the same cycle as `evt_valid & evt_ready`.
- **Repeat timing.** A press granted at edge g with the button held gives:
  - first repeat request set at edge g+HOLD_CYC;
  - subsequent repeat requests every REPEAT_CYC cycles.
- **Stall behaviour.** Counters keep running while the output is stalled.
- **Wrap-around.** `ptr` wraps from N_BTN−1 to 0.

## Test plan
- **Single press/release.** N_BTN=4, `evt_ready`=1; raise `btn_in[2]` for 10 cycles, then lower it. Expect:
  - (01, 2) two cycles after the rise;
  - (10, 2) two cycles after the fall;
  - no other events.
- **Round-robin.** All four buttons rise in the same cycle, `evt_ready`=1. Expect ids 0, 1, 2, 3 on consecutive cycles, all with type 01. A next simultaneous release starts at id 0 (ptr wrapped).
- **Backpressure.** Press buttons 1 and 3 with `evt_ready`=0 for 20 cycles. Expect:
  - (01, 1) held stable throughout the stall;
  - after `evt_ready`=1, (01, 3) follows on the next cycle.
- **Auto-repeat.** HOLD_CYC=8, REPEAT_CYC=4; hold button 0 for 30 cycles. Expect:
  - repeat events 8 cycles after the press grant, then every 4 cycles (5 repeats total);
  - a release last;
  - `drop_cnt`=0.
- **Repeat drop.** Same parameters with `evt_ready`=0 after the press is accepted. Expect `drop_cnt` to increment once per REPEAT_CYC after the first repeat becomes pending, saturating at 255 in a long run.
- **Reset mid-operation.** Assert `rst_n`=0 for one cycle while `evt_valid`=1 and the button is held. Expect `evt_valid`=0 and `drop_cnt`=0, then a fresh (01, id) two cycles after release of reset.
